// File: rtl/jt10_adpcma_pkg.sv
// Shared constants and types for the six-channel ADPCM-A decoder pipeline.
package jt10_adpcma_pkg;

  localparam int NUM_CH  = 6;
  localparam int ACC_W   = 12;
  localparam int IDX_W   = 6;
  localparam int IDX_MAX = 48;
  localparam int STEP_W  = 11;

  localparam logic [STEP_W-1:0] STEP_TAB [0:IDX_MAX] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  localparam logic signed [4:0] ADJ [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd5, 5'sd7, 5'sd9
  };

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [IDX_W-1:0] idx;
  } ch_state_t;

endpackage

// File: rtl/jt10_adpcma_step.sv
// Step-size ROM lookup and clamped step-index update for one nibble.
module jt10_adpcma_step
  import jt10_adpcma_pkg::*;
(
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [2:0]        mag_i,
  output logic [STEP_W-1:0] step_o,
  output logic [IDX_W-1:0]  idx_next_o
);

  logic signed [4:0] adj_s;
  logic signed [7:0] sum_s;

  // Lookup uses the old index; the new index is clamped into 0..IDX_MAX.
  always_comb begin
    adj_s = ADJ[mag_i];
    sum_s = $signed({2'b00, idx_i}) + $signed({{3{adj_s[4]}}, adj_s});
    if (idx_i <= IDX_W'(IDX_MAX)) begin
      step_o = STEP_TAB[idx_i];
    end else begin
      step_o = STEP_TAB[IDX_MAX];
    end
    if (sum_s[7]) begin
      idx_next_o = '0;
    end else if (sum_s[6:0] > 7'(IDX_MAX)) begin
      idx_next_o = IDX_W'(IDX_MAX);
    end else begin
      idx_next_o = sum_s[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/jt10_adpcma_pipe.sv
// Six-slot time-multiplexed ADPCM-A decoder; channel state circulates through
// a 6-register ring so each slot's state returns to the input stage every 6 cen edges.
module jt10_adpcma_pipe
  import jt10_adpcma_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic [3:0]         data,
  input  logic               chon,
  output logic signed [15:0] pcm
);

  // Stage 1: old acc, new idx, looked-up step, nibble
  logic [ACC_W-1:0]  acc1_q, acc1_d;
  logic [IDX_W-1:0]  idx1_q, idx1_d;
  logic [STEP_W-1:0] step1_q, step1_d;
  logic [3:0]        data1_q;
  logic              chon1_q;
  // Stage 2: delta computed by shift-add
  logic [ACC_W-1:0]  acc2_q, delta2_q, delta2_d;
  logic [IDX_W-1:0]  idx2_q;
  logic              sign2_q, chon2_q;
  // Stages 3..6: updated channel state awaiting its next turn
  ch_state_t         ring_q [3:6];
  ch_state_t         ring_d [3:6];
  logic [15:0]       pcm_q, pcm_d;

  logic [STEP_W-1:0] step_s;
  logic [IDX_W-1:0]  idx_next_s;
  logic [14:0]       prod_s;
  logic [ACC_W-1:0]  acc3_s;

  jt10_adpcma_step u_step (
    .idx_i      (ring_q[6].idx),
    .mag_i      (data[2:0]),
    .step_o     (step_s),
    .idx_next_o (idx_next_s)
  );

  // (2*mag+1)*step built from step<<3/<<2/<<1/<<0, then floored by >>3.
  always_comb begin
    acc1_d  = chon ? ring_q[6].acc : '0;
    idx1_d  = chon ? idx_next_s : '0;
    step1_d = step_s;

    prod_s = {4'b0000, step1_q}
           + (data1_q[0] ? {3'b000, step1_q, 1'b0}  : 15'd0)
           + (data1_q[1] ? {2'b00,  step1_q, 2'b00} : 15'd0)
           + (data1_q[2] ? {1'b0,   step1_q, 3'b000} : 15'd0);
    delta2_d = prod_s[14:3];

    if (!chon2_q) begin
      acc3_s = '0;
    end else if (sign2_q) begin
      acc3_s = acc2_q - delta2_q;
    end else begin
      acc3_s = acc2_q + delta2_q;
    end

    ring_d[3] = '{acc: acc3_s, idx: idx2_q};
    for (int i = 4; i <= 6; i++) begin
      ring_d[i] = ring_q[i-1];
    end
    pcm_d = {ring_q[6].acc, 4'b0000};
  end

  // Pipeline registers; everything advances together on cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc1_q   <= '0;
      idx1_q   <= '0;
      step1_q  <= '0;
      data1_q  <= '0;
      chon1_q  <= 1'b0;
      acc2_q   <= '0;
      idx2_q   <= '0;
      delta2_q <= '0;
      sign2_q  <= 1'b0;
      chon2_q  <= 1'b0;
      for (int i = 3; i <= 6; i++) begin
        ring_q[i] <= '0;
      end
      pcm_q    <= '0;
    end else if (cen) begin
      acc1_q   <= acc1_d;
      idx1_q   <= idx1_d;
      step1_q  <= step1_d;
      data1_q  <= data;
      chon1_q  <= chon;
      acc2_q   <= acc1_q;
      idx2_q   <= idx1_q;
      delta2_q <= delta2_d;
      sign2_q  <= data1_q[3];
      chon2_q  <= chon1_q;
      for (int i = 3; i <= 6; i++) begin
        ring_q[i] <= ring_d[i];
      end
      pcm_q    <= pcm_d;
    end
  end

  assign pcm = $signed(pcm_q);

endmodule

// File: tb/tb_jt10_adpcma_pipe.sv
// Scoreboard bench: a per-slot behavioural model predicts each pcm six cen edges ahead.
module tb_jt10_adpcma_pipe;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cen;
  logic [3:0]         data;
  logic               chon;
  logic signed [15:0] pcm;

  jt10_adpcma_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .data  (data),
    .chon  (chon),
    .pcm   (pcm)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int step_tab [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                        73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
                        253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724,
                        796, 876, 963, 1060, 1166, 1282, 1411, 1552};
  int adj [8] = '{-1, -1, -1, -1, 2, 5, 7, 9};
  int m_acc [6];
  int m_idx [6];
  int slot;
  logic signed [15:0] exp_q [$];
  logic signed [15:0] last_exp;

  task automatic check(input string tag, input logic signed [15:0] obs,
                       input logic signed [15:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: pcm=%0d expected %0d", tag, obs, expv);
  endtask

  function automatic logic signed [15:0] model(input int s, input logic [3:0] d,
                                                input logic c);
    int mag;
    int st;
    int dl;
    if (!c) begin
      m_acc[s] = 0;
      m_idx[s] = 0;
    end else begin
      mag = int'(d[2:0]);
      st  = step_tab[m_idx[s]];
      dl  = ((2 * mag + 1) * st) >> 3;
      m_acc[s] = d[3] ? m_acc[s] - dl : m_acc[s] + dl;
      m_acc[s] = m_acc[s] & 4095;
      if (m_acc[s] >= 2048) m_acc[s] = m_acc[s] - 4096;
      m_idx[s] = m_idx[s] + adj[mag];
      if (m_idx[s] < 0) m_idx[s] = 0;
      if (m_idx[s] > 48) m_idx[s] = 48;
    end
    return 16'(m_acc[s] * 16);
  endfunction

  task automatic tick(input logic [3:0] d, input logic c);
    data = d;
    chon = c;
    cen  = 1'b1;
    exp_q.push_back(model(slot, d, c));
    slot = (slot + 1) % 6;
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check($sformatf("stream_slot%0d", (slot + 5) % 6), pcm, last_exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cen   = 1'b0;
    chon  = 1'b0;
    data  = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset", pcm, 16'sd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m_acc[i] = 0;
      m_idx[i] = 0;
    end
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(16'sd0);
    slot = 0;
  endtask

  initial begin
    // Reset, then all channels off for 12 cycles
    do_reset();
    for (int i = 0; i < 12; i++) tick(4'($urandom_range(0, 15)), 1'b0);

    // Nibble 0x0 on slot 0 from reset
    do_reset();
    tick(4'h0, 1'b1);
    for (int i = 0; i < 5; i++) tick(4'h0, 1'b0);
    tick(4'h0, 1'b0);
    check("nib0_pcm32", pcm, 16'sd32);

    // Negative nibbles 0x8 twice
    do_reset();
    tick(4'h8, 1'b1);
    for (int i = 0; i < 5; i++) tick(4'h0, 1'b0);
    tick(4'h8, 1'b1);
    check("nib8_first", pcm, -16'sd32);
    for (int i = 0; i < 5; i++) tick(4'h0, 1'b0);
    tick(4'h0, 1'b0);
    check("nib8_second", pcm, -16'sd64);

    // Repeated 0x7: idx climbs, saturates at 48, acc wraps
    do_reset();
    for (int p = 0; p < 20; p++) begin
      tick(4'h7, 1'b1);
      if (p == 1) check("nib7_first", pcm, 16'sd480);
      if (p == 2) check("nib7_second", pcm, 16'sd1584);
      for (int i = 0; i < 5; i++) tick(4'h0, 1'b0);
    end

    // Independent streams on all slots; slot 3 off for one pass
    do_reset();
    for (int p = 0; p < 20; p++) begin
      for (int s = 0; s < 6; s++) begin
        tick(4'($urandom_range(0, 15)), !(p == 10 && s == 3));
        if (p == 11 && s == 3) check("slot3_off", pcm, 16'sd0);
      end
      if (p == 5) begin
        cen = 1'b0;
        for (int i = 0; i < 4; i++) begin
          data = 4'($urandom_range(0, 15));
          chon = 1'b1;
          @(posedge clk);
          #1;
          check("cen_hold", pcm, last_exp);
        end
      end
    end

    // Asynchronous reset mid-stream clears output at once
    for (int i = 0; i < 3; i++) tick(4'h7, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset", pcm, 16'sd0);
    do_reset();
    for (int i = 0; i < 12; i++) tick(4'($urandom_range(0, 15)), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
